alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the ALU (range 2..8).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the operand and result width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  meaning per-requester operation valid.
REQ-006 SHALL have port req_ready  output  NREQ  meaning per-requester operation accepted this cycle.
REQ-007 SHALL have port req_op  input  4*NREQ  meaning the ALU op code of requester i in bits [4i+3:4i].
REQ-008 SHALL have port req_a  input  WIDTH*NREQ  meaning operand 1 of requester i.
REQ-009 SHALL have port req_b  input  WIDTH*NREQ  meaning operand 2 of requester i.
REQ-010 SHALL have port rsp_valid  output  1  meaning a result is presented.
REQ-011 SHALL have port rsp_ready  input  1  meaning the consumer accepts the result.
REQ-012 SHALL have port rsp_id  output  3  meaning the index of the requester that owns the result.
REQ-013 SHALL have port rsp_result  output  WIDTH  meaning the registered ALU result.
REQ-014 SHALL have port rsp_zero  output  1  meaning the registered ALU zero flag.
REQ-015 SHALL have port rsp_err  output  1  meaning the op code was not a legal ALU op.

Function
REQ-016 SHALL implement FSM states IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-017 SHALL assert at most one req_ready bit per cycle, and only in IDLE or in HOLD when rsp_ready=1 (result drains this cycle).
REQ-018 SHALL grant round-robin: search starts at index ptr, where ptr = (last granted index + 1) mod NREQ.
REQ-019 SHALL transfer an operation when req_valid[i] and req_ready[i] are both 1; the ALU result, zero and id SHALL be registered on that edge and rsp_valid SHALL be 1 the next cycle (latency 1).
REQ-020 SHALL hold rsp_result, rsp_id, rsp_zero and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL, on a simultaneous drain and accept in HOLD, stay in HOLD with the new result (one op per cycle throughput).
REQ-022 SHALL move HOLD->IDLE when rsp_ready=1 and no request is granted, and IDLE->HOLD on any accept.
REQ-023 SHALL support the legal op codes AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLT 0100, SLL 1001, SRA 1010; shifts use operand 2 bits [4:0]; ADD/SUB wrap modulo 2^WIDTH.
REQ-024 SHALL, on any other op code, return result 0, zero 1 and rsp_err 1, and the op SHALL still consume a grant.
REQ-025 SHALL leave ptr unchanged in cycles with no grant.
REQ-026 SHALL never assert req_ready[i] when req_valid[i]=0.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, enter IDLE, set ptr=0, and drive rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, req_ready=0.
REQ-028 SHALL discard any result held in HOLD when reset is asserted mid-operation; no response is issued for it.

Configuration
REQ-029 SHALL, with macro ALU_ARBITER_STATS_EN defined, add output grant_cnt (16*NREQ) holding per-requester saturating 16-bit accept counters, reset to 0, which stop incrementing at 0xFFFF.
REQ-030 SHALL, without ALU_ARBITER_STATS_EN, omit grant_cnt and all counter logic.

Structure
REQ-031 SHALL take ALU op-code constants and the FSM state encoding from the shared alu_pkg package.
REQ-032 SHALL instantiate the existing alu module once as its only sub-module; the arbitration and FSM remain in alu_arbiter.

Verification
REQ-033 SHALL cover: reset then req_valid=0001, op=ADD, a=5, b=7 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-034 SHALL cover: req_valid=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-035 SHALL cover: rsp_ready=0 for 3 cycles with a result held -> req_ready=0 and outputs stable; rsp_ready=1 -> drain and new accept in the same cycle.
REQ-036 SHALL cover: SUB a=3, b=3 -> result 0, zero 1; SRA a=0x80000000, b=4 -> 0xF8000000; op=1111 -> result 0, rsp_err 1.
REQ-037 SHALL cover: rst_n=0 while in HOLD -> next cycle rsp_valid=0 and ptr=0, so the first grant after reset goes to requester 0.
REQ-038 SHALL cover, with ALU_ARBITER_STATS_EN: 70000 accepts by requester 2 -> grant_cnt for requester 2 equals 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, arbiter FSM encoding, round-robin index helper.
// Latency: none (package only).
// Backpressure: not applicable.
package alu_pkg;

  // ALU op codes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  // Arbiter FSM: IDLE holds nothing, HOLD presents a result
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // (base + off) mod n for requester indices, with base < n and off < n
  function automatic logic [2:0] rr_idx(input logic [2:0] base,
                                        input int unsigned off,
                                        input int unsigned n);
    int unsigned s;
    s = int'(base) + off;
    if (s >= n) s = s - n;
    return 3'(s);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic, add/sub, signed compare and shifts; illegal ops flag an error.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  // Operation select; shift amount is the low 5 bits of operand 2
  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: result = a + b;
      OP_XOR: result = a ^ b;
      OP_SUB: result = a - b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: result = a << b[4:0];
      OP_SRA: result = $signed(a) >>> b[4:0];
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters; optional per-requester
// accept counters under ALU_ARBITER_STATS_EN. Latency: 1 cycle accept-to-rsp_valid.
// Backpressure: no grant while a result is held and rsp_ready=0; drain+accept same cycle keeps 1 op/cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [16*NREQ-1:0]    grant_cnt
`endif
);

  arb_state_t       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             can_accept;
  logic             gnt_vld;
  logic [2:0]       gnt_idx;
  logic [2:0]       cand;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_err;

  // Round-robin search from ptr; no grant during reset or while a held result is not draining
  always_comb begin
    can_accept = (state_q == ST_IDLE) || rsp_ready;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_idx(ptr_q, k, NREQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!can_accept || !rst_n) gnt_vld = 1'b0;
    req_ready = gnt_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

  // Operand mux feeding the shared ALU from the granted requester
  always_comb begin
    sel_op = req_op[4*int'(gnt_idx) +: 4];
    sel_a  = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
    sel_b  = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // Next-state: capture on grant, fall to IDLE on drain without a new grant
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (gnt_vld) begin
      state_d  = ST_HOLD;
      ptr_d    = rr_idx(gnt_idx, 1, NREQ);
      id_d     = gnt_idx;
      result_d = alu_result;
      zero_d   = alu_zero;
      err_d    = alu_err;
    end else if (state_q == ST_HOLD && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // FSM and response registers; reset drops any held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign rsp_valid  = (state_q == ST_HOLD);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  // Saturating per-requester accept counters
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_vld && gnt_idx == 3'(i) && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle model compared on every negedge plus directed literals.
// Latency checked: 1 cycle accept-to-rsp_valid.
// Backpressure checked: held results stay stable, drain+accept in the same cycle.
module tb_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
`ifdef ALU_ARBITER_STATS_EN
  logic [16*NREQ-1:0]    grant_cnt;
`endif

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written from the op-code table: {err, zero, result}
  function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    r = 32'd0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0101: r = a ^ b;
      4'b0110: r = a - b;
      4'b0100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: r = a << b[4:0];
      4'b1010: r = $signed(a) >>> b[4:0];
      default: e = 1'b1;
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  // Model state: what the response side must look like this cycle
  logic        m_known = 1'b0;
  logic        m_valid;
  int          m_ptr;
  int          m_id;
  logic [33:0] m_rsp;

  // Compare DUT against model each negedge, then advance model to the next cycle
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    g = -1;
    if (rst_n && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (m_known) begin
      chk("m_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
      chk("m_req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
      if (m_valid) begin
        chk("m_rsp_id", {61'd0, rsp_id}, 64'(m_id));
        chk("m_rsp_result", {32'd0, rsp_result}, {32'd0, m_rsp[31:0]});
        chk("m_rsp_zero", {63'd0, rsp_zero}, {63'd0, m_rsp[32]});
        chk("m_rsp_err", {63'd0, rsp_err}, {63'd0, m_rsp[33]});
      end
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_ptr   = 0;
      m_id    = 0;
      m_rsp   = '0;
    end else if (m_known) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_id    = g;
        m_rsp   = ref_alu(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One-cycle request from requester i with rsp_ready high; returns at posedge+1
  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    set_req(i, op, a, b);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    rsp_ready    = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic chk_rsp(input string nm, input logic [31:0] r, input logic z, input logic e);
    chk({nm, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({nm, "_result"}, {32'd0, rsp_result}, {32'd0, r});
    chk({nm, "_zero"}, {63'd0, rsp_zero}, {63'd0, z});
    chk({nm, "_err"}, {63'd0, rsp_err}, {63'd0, e});
  endtask

  logic [2:0] rr_exp [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_id", {61'd0, rsp_id}, 64'd0);
    chk("rst_result", {32'd0, rsp_result}, 64'd0);
    chk("rst_zero", {63'd0, rsp_zero}, 64'd0);
    chk("rst_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);

    // First op after reset: ADD 5+7 from requester 0
    rst_n = 1'b1;
    issue(0, 4'b0010, 32'd5, 32'd7);
    chk("add_id", {61'd0, rsp_id}, 64'd0);
    chk_rsp("add", 32'd12, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Round-robin over all four after a fresh reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 4'b0010, 32'd10, 32'd20);
    set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    set_req(2, 4'b0101, 32'hFFFF_0000, 32'h0F0F_0F0F);
    set_req(3, 4'b0100, 32'd3, 32'hFFFF_FFFE);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd3; rr_exp[4] = 3'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_id%0d", c), {61'd0, rsp_id}, {61'd0, rr_exp[c]});
      chk($sformatf("rr_valid%0d", c), {63'd0, rsp_valid}, 64'd1);
    end
    req_valid = '0;
    @(posedge clk); #1;

    // Backpressure: hold requester 1's AND result for 3 cycles, then drain+accept requester 3
    issue(1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    set_req(3, 4'b0110, 32'd9, 32'd4);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), {60'd0, req_ready}, 64'd0);
      chk($sformatf("bp_id%0d", c), {61'd0, rsp_id}, 64'd1);
      chk_rsp($sformatf("bp%0d", c), 32'h0000_F000, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {60'd0, req_ready}, 64'h8);
    @(posedge clk); #1;
    req_valid = '0;
    chk("bp_new_id", {61'd0, rsp_id}, 64'd3);
    chk_rsp("bp_new", 32'd5, 1'b0, 1'b0);

    // Op coverage and boundaries
    issue(0, 4'b0110, 32'd3, 32'd3);
    chk_rsp("sub_zero", 32'd0, 1'b1, 1'b0);
    issue(1, 4'b1010, 32'h8000_0000, 32'd4);
    chk_rsp("sra", 32'hF800_0000, 1'b0, 1'b0);
    issue(2, 4'b1111, 32'd123, 32'd456);
    chk_rsp("illegal", 32'd0, 1'b1, 1'b1);
    chk("illegal_id", {61'd0, rsp_id}, 64'd2);
    issue(3, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    chk_rsp("add_wrap", 32'd0, 1'b1, 1'b0);
    issue(0, 4'b0100, 32'hFFFF_FFFF, 32'd1);
    chk_rsp("slt_neg", 32'd1, 1'b0, 1'b0);
    issue(1, 4'b1001, 32'd1, 32'h0000_0024);
    chk_rsp("sll_mask", 32'd16, 1'b0, 1'b0);
    issue(2, 4'b0011, 32'd1, 32'd1);
    chk_rsp("illegal3", 32'd0, 1'b1, 1'b1);

    // Reset while holding a result: it is discarded and ptr returns to 0
    issue(2, 4'b0010, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("hold_before_rst", {63'd0, rsp_valid}, 64'd1);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_hold_ready", {60'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_valid", {63'd0, rsp_valid}, 64'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", {60'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    chk("post_rst_id", {61'd0, rsp_id}, 64'd0);
    req_valid = '0;
    @(posedge clk); #1;

`ifdef ALU_ARBITER_STATS_EN
    // Saturation of requester 2's accept counter
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("cnt_rst", grant_cnt, 64'd0);
    rst_n = 1'b1;
    set_req(2, 4'b0010, 32'd1, 32'd1);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("cnt2_10", {48'd0, grant_cnt[47:32]}, 64'd10);
    repeat (69990) @(posedge clk);
    #1;
    chk("cnt2_sat", {48'd0, grant_cnt[47:32]}, 64'hFFFF);
    chk("cnt0_zero", {48'd0, grant_cnt[15:0]}, 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
